// File: rtl/write_rawdata.sv
// write_rawdata: streams one frame of 16-bit raw Bayer pixels into the framed
// SD-card sector layout (picture header, rows of header/pixels/trailer,
// picture trailer, then pad up to a whole sector).
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   start, sec_base begin a frame at sector sec_base (ignored while busy)
//   wr_busy, wr_req SD write controller status and per-word data request
//   wr_start_en     one-cycle sector write start pulse
//   wr_sec_addr     sector address of the current sector write
//   wr_data         word returned to the SD controller, valid the cycle after wr_req
//   pix_data/empty  first-word-fall-through pixel FIFO head and empty flag
//   pix_rd_en       FIFO pop; combinational so the head is consumed in the same
//                   cycle it is sampled, which keeps back-to-back requests correct
//   busy, done      frame in progress / one-cycle frame completion pulse
//   underflow       sticky: a pixel was needed while the FIFO was empty
`timescale 1ns/1ps
module write_rawdata #(
  parameter int unsigned PIC_HEAD_NUM = 7744,
  parameter int unsigned ROW_HEAD_NUM = 8,
  parameter int unsigned ROW_PIX_NUM  = 1920,
  parameter int unsigned ROW_END_NUM  = 8,
  parameter int unsigned ROW_NUM      = 1080,
  parameter int unsigned PIC_END_NUM  = 7744,
  parameter int unsigned SEC_WORDS    = 256,
  parameter logic [15:0] FILL_WORD    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sec_base,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  input  logic [15:0] pix_data,
  input  logic        pix_empty,
  output logic        pix_rd_en,
  output logic        busy,
  output logic        done,
  output logic        underflow
);

  localparam int unsigned ROW_LEN     = ROW_HEAD_NUM + ROW_PIX_NUM + ROW_END_NUM;
  localparam int unsigned TOTAL_WORDS = PIC_HEAD_NUM + ROW_NUM * ROW_LEN + PIC_END_NUM;
  localparam int unsigned SEC_NUM     = (TOTAL_WORDS + SEC_WORDS - 1) / SEC_WORDS;

  localparam int unsigned SEC_CNT_W = 26;
  localparam int unsigned HDR_CNT_W = 15;
  localparam int unsigned PIX_CNT_W = 12;

  localparam logic [SEC_CNT_W-1:0] SEC_LAST      = SEC_CNT_W'(SEC_NUM - 1);
  localparam logic [HDR_CNT_W-1:0] PIC_HEAD_LAST = HDR_CNT_W'(PIC_HEAD_NUM - 1);
  localparam logic [HDR_CNT_W-1:0] ROW_HEAD_LAST = HDR_CNT_W'(ROW_HEAD_NUM - 1);
  localparam logic [HDR_CNT_W-1:0] ROW_END_LAST  = HDR_CNT_W'(ROW_END_NUM - 1);
  localparam logic [HDR_CNT_W-1:0] PIC_END_LAST  = HDR_CNT_W'(PIC_END_NUM - 1);
  localparam logic [PIX_CNT_W-1:0] ROW_PIX_LAST  = PIX_CNT_W'(ROW_PIX_NUM - 1);
  localparam logic [PIX_CNT_W-1:0] ROW_NUM_LAST  = PIX_CNT_W'(ROW_NUM - 1);

  typedef enum logic [1:0] {
    SEC_IDLE,
    SEC_ISSUE,
    SEC_WAIT
  } sec_state_t;

  typedef enum logic [2:0] {
    W_PIC_HEAD,
    W_ROW_HEAD,
    W_ROW_DATA,
    W_ROW_END,
    W_PIC_END,
    W_PAD
  } word_state_t;

  sec_state_t           sec_state;
  word_state_t          word_state;
  logic [SEC_CNT_W-1:0] sec_cnt;
  logic [HDR_CNT_W-1:0] hdr_cnt;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [PIX_CNT_W-1:0] row_cnt;
  logic                 busy_d0;
  logic                 busy_d1;

  logic busy_fall;
  logic start_ok;
  logic frame_end;
  logic word_take;

  // SD controller completion, seen two cycles after wr_busy drops
  assign busy_fall = busy_d1 & ~busy_d0;
  assign start_ok  = start & (sec_state == SEC_IDLE);
  assign frame_end = (sec_state == SEC_WAIT) & busy_fall & (sec_cnt == SEC_LAST);
  assign word_take = busy & wr_req;
  assign pix_rd_en = word_take & (word_state == W_ROW_DATA) & ~pix_empty;

  // Sector FSM: issues one start pulse per sector and walks the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_state   <= SEC_IDLE;
      sec_cnt     <= '0;
      wr_sec_addr <= '0;
      wr_start_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      busy_d0     <= 1'b0;
      busy_d1     <= 1'b0;
    end else begin
      wr_start_en <= 1'b0;
      done        <= 1'b0;
      busy_d0     <= wr_busy;
      busy_d1     <= busy_d0;
      case (sec_state)
        SEC_IDLE: begin
          if (start) begin
            wr_sec_addr <= sec_base;
            sec_cnt     <= '0;
            busy        <= 1'b1;
            sec_state   <= SEC_ISSUE;
          end
        end
        SEC_ISSUE: begin
          wr_start_en <= 1'b1;
          sec_state   <= SEC_WAIT;
        end
        SEC_WAIT: begin
          if (busy_fall) begin
            if (sec_cnt == SEC_LAST) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              sec_state <= SEC_IDLE;
            end else begin
              sec_cnt     <= sec_cnt + SEC_CNT_W'(1);
              wr_sec_addr <= wr_sec_addr + 32'd1;
              sec_state   <= SEC_ISSUE;
            end
          end
        end
        default: sec_state <= SEC_IDLE;
      endcase
    end
  end

  // Word FSM: one step per accepted request, selecting fill or pixel data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_state <= W_PIC_HEAD;
      hdr_cnt    <= '0;
      pix_cnt    <= '0;
      row_cnt    <= '0;
      wr_data    <= '0;
      underflow  <= 1'b0;
    end else if (frame_end || start_ok) begin
      word_state <= W_PIC_HEAD;
      hdr_cnt    <= '0;
      pix_cnt    <= '0;
      row_cnt    <= '0;
      if (start_ok) begin
        underflow <= 1'b0;
      end
    end else if (word_take) begin
      wr_data <= FILL_WORD;
      case (word_state)
        W_PIC_HEAD: begin
          if (hdr_cnt == PIC_HEAD_LAST) begin
            hdr_cnt    <= '0;
            word_state <= W_ROW_HEAD;
          end else begin
            hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
          end
        end
        W_ROW_HEAD: begin
          if (hdr_cnt == ROW_HEAD_LAST) begin
            hdr_cnt    <= '0;
            word_state <= W_ROW_DATA;
          end else begin
            hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
          end
        end
        W_ROW_DATA: begin
          // a starved pixel slot is still consumed so the frame length holds
          if (pix_empty) begin
            underflow <= 1'b1;
          end else begin
            wr_data <= pix_data;
          end
          if (pix_cnt == ROW_PIX_LAST) begin
            pix_cnt    <= '0;
            word_state <= W_ROW_END;
          end else begin
            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
          end
        end
        W_ROW_END: begin
          if (hdr_cnt == ROW_END_LAST) begin
            hdr_cnt <= '0;
            if (row_cnt == ROW_NUM_LAST) begin
              row_cnt    <= '0;
              word_state <= W_PIC_END;
            end else begin
              row_cnt    <= row_cnt + PIX_CNT_W'(1);
              word_state <= W_ROW_HEAD;
            end
          end else begin
            hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
          end
        end
        W_PIC_END: begin
          if (hdr_cnt == PIC_END_LAST) begin
            hdr_cnt    <= '0;
            word_state <= W_PAD;
          end else begin
            hdr_cnt <= hdr_cnt + HDR_CNT_W'(1);
          end
        end
        W_PAD: word_state <= W_PAD;
        default: word_state <= W_PIC_HEAD;
      endcase
    end
  end

endmodule

// File: tb/tb_write_rawdata.sv
// tb_write_rawdata: reduced-size frame (32 words in 12-word sectors, so the
// last sector carries 4 pad words). A behavioural SD controller and FIFO
// drive the DUT; a reference model builds the expected address and word
// streams from the frame layout, and a monitor compares them as they appear.
`timescale 1ns/1ps
module tb_write_rawdata;

  localparam int unsigned PIC    = 4;
  localparam int unsigned RH     = 2;
  localparam int unsigned RP     = 8;
  localparam int unsigned RE     = 2;
  localparam int unsigned RN     = 2;
  localparam int unsigned PE     = 4;
  localparam int unsigned SW     = 12;
  localparam logic [15:0] FILL   = 16'hA5A5;
  localparam int unsigned ROWLEN = RH + RP + RE;
  // 4 + 2*12 + 4 = 32 words, three 12-word sectors
  localparam int unsigned SECS   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] sec_base;
  logic        wr_busy;
  logic        wr_req;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic        pix_rd_en;
  logic        busy;
  logic        done;
  logic        underflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr[$];
  logic [15:0] exp_word[$];
  logic [15:0] fifo[$];
  logic        head_empty = 1'b1;
  logic        starve = 1'b0;
  logic        idle_test = 1'b0;
  logic        req_q;
  logic        pop_q;
  int          pop_cnt = 0;
  int          done_cnt = 0;

  write_rawdata #(
    .PIC_HEAD_NUM(PIC), .ROW_HEAD_NUM(RH), .ROW_PIX_NUM(RP), .ROW_END_NUM(RE),
    .ROW_NUM(RN), .PIC_END_NUM(PE), .SEC_WORDS(SW), .FILL_WORD(FILL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sec_base(sec_base),
    .wr_busy(wr_busy), .wr_req(wr_req), .wr_start_en(wr_start_en),
    .wr_sec_addr(wr_sec_addr), .wr_data(wr_data), .pix_data(pix_data),
    .pix_empty(pix_empty), .pix_rd_en(pix_rd_en), .busy(busy), .done(done),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign pix_empty = head_empty | starve;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit is_pix(input int w);
    int r;
    if (w < int'(PIC) || w >= int'(PIC + RN * ROWLEN)) return 1'b0;
    r = (w - int'(PIC)) % int'(ROWLEN);
    return (r >= int'(RH)) && (r < int'(RH + RP));
  endfunction

  // request / pop history sampled at the active edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
      pop_q <= 1'b0;
    end else begin
      req_q <= wr_req & ~idle_test;
      pop_q <= pix_rd_en;
    end
  end

  // FWFT FIFO model: pops land between edges, head republished each cycle
  always @(negedge clk) begin
    if (pop_q) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pop_cnt++;
    end
    head_empty = (fifo.size() == 0);
    pix_data   = (fifo.size() > 0) ? fifo[0] : 16'h0000;
  end

  // monitor: compares sector addresses and returned words against the scoreboard
  always @(negedge clk) begin
    if (wr_start_en) begin
      if (exp_addr.size() == 0) check("addr_unexpected", 64'(wr_sec_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("sector_addr", 64'(wr_sec_addr), 64'(exp_addr.pop_front()));
    end
    if (req_q) begin
      if (exp_word.size() == 0) check("word_unexpected", 64'(wr_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else check("word_data", 64'(wr_data), 64'(exp_word.pop_front()));
    end
    if (done) done_cnt++;
  end

  task automatic hard_reset();
    rst = 1'b1;
    wr_req = 1'b0;
    starve = 1'b0;
    #1;
    check("reset_outputs", 64'({wr_start_en, wr_sec_addr, wr_data, pix_rd_en, busy, done, underflow}), 64'd0);
    exp_addr.delete();
    exp_word.delete();
    @(negedge clk);
    rst = 1'b0;
    wr_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] base, input int starve_idx, input int abort_sec,
                           input bit mid_start, input bit inc);
    logic [15:0] pixq[$];
    logic [15:0] v;
    int exp_pops, pop0, done0, req_idx, n;

    fifo.delete();
    for (int i = 0; i < int'(RN * RP); i++) begin
      v = inc ? 16'(i + 1) : 16'($urandom);
      fifo.push_back(v);
      pixq.push_back(v);
    end
    @(negedge clk);

    // reference: layout by word index, pixels drawn in order, starved slot is fill
    exp_pops = 0;
    for (int s = 0; s < int'(SECS); s++) exp_addr.push_back(base + 32'(s));
    for (int w = 0; w < int'(SECS * SW); w++) begin
      if (is_pix(w) && w != starve_idx) begin
        exp_word.push_back(pixq.pop_front());
        exp_pops++;
      end else begin
        exp_word.push_back(FILL);
      end
    end

    pop0  = pop_cnt;
    done0 = done_cnt;
    start = 1'b1;
    sec_base = base;
    @(negedge clk);
    start = 1'b0;
    sec_base = $urandom;
    check("start_busy", 64'(busy), 64'd1);
    check("start_underflow_clr", 64'(underflow), 64'd0);

    req_idx = 0;
    for (int s = 0; s < int'(SECS); s++) begin
      n = 0;
      while (!wr_start_en && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!wr_start_en) begin
        check("sector_start_timeout", 64'd0, 64'd1);
        hard_reset();
        return;
      end
      wr_busy = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int k = 0; k < int'(SW); k++) begin
        if (s == abort_sec && k == 5) begin
          @(negedge clk);
          hard_reset();
          return;
        end
        starve = (req_idx == starve_idx);
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        starve = 1'b0;
        req_idx++;
        if (mid_start && s == 1 && k == 3) begin
          start = 1'b1;
          sec_base = 32'hDEAD_0000;
          @(negedge clk);
          start = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      wr_busy = 1'b0;
      if (s == int'(SECS) - 1) begin
        @(negedge clk);
        check("done_early", 64'(done), 64'd0);
        @(negedge clk);
        check("done_timing", 64'(done), 64'd1);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
      end
    end

    check("addr_left", 64'(exp_addr.size()), 64'd0);
    check("words_left", 64'(exp_word.size()), 64'd0);
    check("pop_count", 64'(pop_cnt - pop0), 64'(exp_pops));
    check("done_count", 64'(done_cnt - done0), 64'd1);
    check("underflow_flag", 64'(underflow), 64'(starve_idx >= 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int sidx;
    rst = 1'b1;
    start = 1'b0;
    sec_base = '0;
    wr_busy = 1'b0;
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({wr_start_en, wr_sec_addr, wr_data, pix_rd_en, busy, done, underflow}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // incrementing pixels 1..16 at sector 100
    run_frame(32'd100, -1, -1, 1'b0, 1'b1);

    // request while idle: no pop, wr_data keeps the last pad word
    fifo.push_back(16'h1234);
    @(negedge clk);
    idle_test = 1'b1;
    wr_req = 1'b1;
    #1;
    check("idle_rd_en", 64'(pix_rd_en), 64'd0);
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    idle_test = 1'b0;
    check("idle_data", 64'(wr_data), 64'(FILL));
    check("idle_busy", 64'(busy), 64'd0);

    // FIFO empty for the 3rd pixel of row 0, plus an ignored mid-frame start
    run_frame($urandom, int'(PIC + RH + 2), -1, 1'b1, 1'b0);

    // address wrap, random starved pixel
    sidx = int'(PIC) + int'($urandom_range(0, RN - 1)) * int'(ROWLEN) + int'(RH)
           + int'($urandom_range(0, RP - 1));
    run_frame(32'hFFFF_FFFF, sidx, -1, 1'b0, 1'b0);

    // reset while waiting on sector 1, then a clean frame at 500
    run_frame($urandom, -1, 1, 1'b0, 1'b0);
    run_frame(32'd500, -1, -1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      sidx = ($urandom_range(0, 1) == 1)
           ? int'(PIC) + int'($urandom_range(0, RN - 1)) * int'(ROWLEN) + int'(RH)
             + int'($urandom_range(0, RP - 1))
           : -1;
      run_frame($urandom, sidx, -1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_rawdata.md
Name: write_rawdata

Overview:
- Transmit-side counterpart to the SD raw-frame reader: converts one frame of 16-bit raw Bayer pixels into the framed SD-card sector layout.
- Frame layout, in order: picture header, then per row a row header, row pixels and row trailer, then the picture trailer.
- Drives the SD write controller with sector start pulses and sequential sector addresses, and returns one data word per write request.
- Pixels are consumed from a first-word-fall-through FIFO fed by the DDR read path.

Parameters:
- PIC_HEAD_NUM, 7744: picture header length, in 16-bit words.
- ROW_HEAD_NUM, 8: row header length, in words.
- ROW_PIX_NUM, 1920: pixel words per row.
- ROW_END_NUM, 8: row trailer length, in words.
- ROW_NUM, 1080: rows per frame.
- PIC_END_NUM, 7744: picture trailer length, in words.
- SEC_WORDS, 256: 16-bit words per SD sector (512 bytes).
- FILL_WORD, 16'h0000: value written for all header, trailer and pad words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins one frame write.
- sec_base  in  32  first sector address; latched on an accepted start.
- wr_busy  in  1  SD write controller busy.
- wr_req  in  1  SD controller requests the next data word.
- wr_start_en  out  1  single-cycle sector-write start pulse.
- wr_sec_addr  out  32  sector address for the current sector write.
- wr_data  out  16  word returned to the SD controller.
- pix_data  in  16  FIFO head word (FWFT).
- pix_empty  in  1  FIFO empty.
- pix_rd_en  out  1  FIFO pop, one cycle.
- busy  out  1  frame write in progress.
- done  out  1  single-cycle pulse when the last sector completes.
- underflow  out  1  sticky flag: a pixel word was needed while pix_empty was high.

Behaviour:
- Reset values: all outputs 0; sector FSM in IDLE; word FSM in PIC_HEAD; all counters 0.
- Derived constants:
  - TOTAL_WORDS = PIC_HEAD_NUM + ROW_NUM*(ROW_HEAD_NUM+ROW_PIX_NUM+ROW_END_NUM) + PIC_END_NUM.
  - SEC_NUM = ceil(TOTAL_WORDS/SEC_WORDS). With defaults this is 2106368 words = 8228 sectors, exactly.
- wr_busy is registered twice. The falling edge is busy_d1 & ~busy_d0, so completion is detected 2 cycles after wr_busy drops.
- Sector FSM:
  - IDLE: on start, latch sec_base into wr_sec_addr, clear sec_cnt, set busy, go to ISSUE.
  - ISSUE: drive wr_start_en=1 for exactly one cycle, go to WAIT.
  - WAIT: on the falling edge of wr_busy:
    - if sec_cnt==SEC_NUM-1: pulse done for one cycle, clear busy, go to IDLE, leave wr_sec_addr unchanged;
    - otherwise increment sec_cnt and wr_sec_addr by 1, go to ISSUE.
  - start is ignored while busy=1.
- Word FSM: advances only on wr_req while busy=1. States:
  - PIC_HEAD: counts PIC_HEAD_NUM words, then goes to ROW_HEAD.
  - ROW_HEAD: counts ROW_HEAD_NUM words, then goes to ROW_DATA.
  - ROW_DATA: counts ROW_PIX_NUM words, then goes to ROW_END.
  - ROW_END: counts ROW_END_NUM words, then increments row_cnt. If row_cnt==ROW_NUM-1, clear row_cnt and go to PIC_END; else go to ROW_HEAD.
  - PIC_END: counts PIC_END_NUM words, then goes to PAD.
  - PAD: serves the remaining words of the last sector; stays in PAD until the frame ends.
- Word FSM returns to PIC_HEAD with all counters cleared on the cycle done pulses.
- Data timing:
  - wr_data is registered and updated on the clock edge that samples wr_req, so it is valid the cycle after wr_req.
  - wr_data holds its value between requests.
- Data values:
  - ROW_DATA, pix_empty=0: wr_data=pix_data and pix_rd_en=1 in the same cycle.
  - ROW_DATA, pix_empty=1: wr_data=FILL_WORD, pix_rd_en=0, underflow set; the word still counts.
  - All other states: wr_data=FILL_WORD and pix_rd_en=0.
- Requests outside a frame: wr_req while busy=0 is ignored; wr_data is unchanged.
- Flags:
  - underflow is cleared only by rst or by an accepted start.
  - Simultaneous start and done: the start is ignored, since busy is still 1 in that cycle.
- Reset mid-frame returns every FSM, counter and flag to its reset state immediately. No partial sector is completed.
- Widths:
  - sec_cnt: 26 bits.
  - word counters: 15 bits (head/trailer) and 12 bits (row pixels / row count).
  - wr_sec_addr wraps modulo 2^32.

Test Plan:
- Reduced parameters: PIC_HEAD=4, ROW_HEAD=2, ROW_PIX=8, ROW_END=2, ROW_NUM=2, PIC_END=4, SEC_WORDS=16 (32 words, 2 sectors).
  - Stimulus: start with sec_base=100; the SD model requests 16 words per sector; the FIFO holds 16 incrementing pixels 1..16.
  - Response: wr_start_en pulses with addresses 100 then 101.
  - Response: word stream is 4×0, 2×0, 1..8, 2×0, 2×0, 9..16, 2×0, 4×0.
  - Response: exactly 16 pix_rd_en pulses; done pulses once; busy falls; underflow=0.
- SEC_WORDS=12, same framing (32 words → 3 sectors):
  - Addresses base..base+2 are issued.
  - The last sector ends with 4 PAD words of FILL_WORD=16'hA5A5.
- FIFO empty for the 3rd pixel of row 0:
  - That word is FILL_WORD and underflow rises and stays high.
  - The remaining pixels are shifted by one position; the total frame length is unchanged.
- Reset asserted in WAIT of sector 1:
  - All outputs return to 0 immediately.
  - A new start with sec_base=500 produces a complete correct frame beginning at 500.
- Robustness:
  - A start pulse mid-frame is ignored: addresses and stream are unchanged.
  - wr_req while idle leaves wr_data and pix_rd_en unchanged.
  - done is exactly one cycle wide and occurs 2 cycles after the final wr_busy fall.
